// File: rtl/apb_pkg.sv
// Shared types and address-map constants for the APB master and its decoder.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_state_e;

  localparam logic [15:0] BASE_HI_DEFAULT = 16'h1000;
  localparam int          HI_LSB          = 16;
  localparam int          IDX_LSB         = 12;
  localparam int          IDX_W           = 4;

endpackage

// File: rtl/apb_decoder.sv
// Combinational slave decode: index from addr[15:12], mapped when the upper
// half matches BASE_HI and the index names an existing slave port.
module apb_decoder
  import apb_pkg::*;
#(
  parameter int          NUM_SLAVES = 8,
  parameter logic [15:0] BASE_HI    = BASE_HI_DEFAULT
) (
  input  logic [31:IDX_LSB]  addr_i,
  output logic [IDX_W-1:0]   index_o,
  output logic               mapped_o
);

  localparam logic [IDX_W:0] NS = IDX_W'(NUM_SLAVES) == '0 ? (IDX_W+1)'(16) : (IDX_W+1)'(NUM_SLAVES);

  assign index_o  = addr_i[IDX_LSB +: IDX_W];
  assign mapped_o = (addr_i[31:HI_LSB] == BASE_HI) && ({1'b0, index_o} < NS);

endmodule

// File: rtl/apb_master_n.sv
// Single-outstanding APB master fanning out to NUM_SLAVES ports, with a
// bounded PREADY wait and a one-cycle registered completion pulse.
module apb_master_n
  import apb_pkg::*;
#(
  parameter int          NUM_SLAVES  = 8,
  parameter int          DATA_W      = 32,
  parameter int          PADDR_W     = 12,
  parameter logic [15:0] BASE_HI     = BASE_HI_DEFAULT,
  parameter int          TIMEOUT_CYC = 255
) (
  input  logic                         PCLK,
  input  logic                         PRESET,
  input  logic                         transfer,
  input  logic                         write,
  input  logic [31:0]                  addr,
  input  logic [DATA_W-1:0]            wdata,
  input  logic [DATA_W/8-1:0]          strb,
  output logic                         ready,
  output logic [DATA_W-1:0]            rdata,
  output logic                         error,
  output logic [PADDR_W-1:0]           PADDR,
  output logic                         PWRITE,
  output logic                         PENABLE,
  output logic [DATA_W-1:0]            PWDATA,
  output logic [DATA_W/8-1:0]          PSTRB,
  output logic [NUM_SLAVES-1:0]        PSEL,
  input  logic [NUM_SLAVES*DATA_W-1:0] PRDATA,
  input  logic [NUM_SLAVES-1:0]        PREADY,
  input  logic [NUM_SLAVES-1:0]        PSLVERR
);

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYC - 1);

  apb_state_e             state_q, state_d;
  logic [15:0]            wait_q, wait_d;
  logic                   ready_q, ready_d;
  logic                   error_q, error_d;
  logic [DATA_W-1:0]      rdata_q, rdata_d;
  logic                   write_q;
  logic [PADDR_W-1:0]     paddr_q;
  logic [DATA_W-1:0]      wdata_q;
  logic [DATA_W/8-1:0]    strb_q;
  logic [IDX_W-1:0]       idx_q;

  logic [IDX_W-1:0]       dec_idx;
  logic                   dec_mapped;
  logic                   latch_en;
  logic                   pready_sel;
  logic                   pslverr_sel;
  logic [DATA_W-1:0]      prdata_sel;

  apb_decoder #(
    .NUM_SLAVES (NUM_SLAVES),
    .BASE_HI    (BASE_HI)
  ) u_dec (
    .addr_i   (addr[31:IDX_LSB]),
    .index_o  (dec_idx),
    .mapped_o (dec_mapped)
  );

  assign latch_en = (state_q == IDLE) && transfer;

  // Only the latched slave's response lines ever reach the FSM.
  always_comb begin
    pready_sel  = 1'b0;
    pslverr_sel = 1'b0;
    prdata_sel  = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (idx_q == IDX_W'(i)) begin
        pready_sel  = PREADY[i];
        pslverr_sel = PSLVERR[i];
        prdata_sel  = PRDATA[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    ready_d = 1'b0;
    error_d = 1'b0;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (transfer) begin
          if (dec_mapped) begin
            state_d = SETUP;
            wait_d  = '0;
          end else begin
            state_d = RESP;
            ready_d = 1'b1;
            error_d = 1'b1;
            rdata_d = '0;
          end
        end
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        if (pready_sel) begin
          state_d = RESP;
          ready_d = 1'b1;
          error_d = pslverr_sel;
          rdata_d = write_q ? '0 : prdata_sel;
        end else if (wait_q == TO_LAST) begin
          state_d = RESP;
          ready_d = 1'b1;
          error_d = 1'b1;
          rdata_d = '0;
        end else begin
          wait_d = wait_q + 16'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      state_q <= IDLE;
      wait_q  <= '0;
      ready_q <= 1'b0;
      error_q <= 1'b0;
      rdata_q <= '0;
      write_q <= 1'b0;
      paddr_q <= '0;
      wdata_q <= '0;
      strb_q  <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      ready_q <= ready_d;
      error_q <= error_d;
      rdata_q <= rdata_d;
      if (latch_en) begin
        write_q <= write;
        paddr_q <= addr[PADDR_W-1:0];
        wdata_q <= wdata;
        strb_q  <= strb;
        idx_q   <= dec_idx;
      end
    end
  end

  always_comb begin
    PSEL = '0;
    if ((state_q == SETUP) || (state_q == ACCESS)) begin
      for (int i = 0; i < NUM_SLAVES; i++) begin
        PSEL[i] = (idx_q == IDX_W'(i));
      end
    end
  end

  assign PENABLE = (state_q == ACCESS);
  assign PADDR   = paddr_q;
  assign PWRITE  = write_q;
  assign PWDATA  = wdata_q;
  assign PSTRB   = strb_q;
  assign ready   = ready_q;
  assign error   = error_q;
  assign rdata   = rdata_q;

endmodule

// File: doc/apb_master_n.md
APB_MASTER_N -- requirements
Module: apb_master_n

Interface
REQ-001 SHALL have parameter NUM_SLAVES, default 8, number of APB slave ports (1..16).
REQ-002 SHALL have parameter DATA_W, default 32, APB data width.
REQ-003 SHALL have parameter PADDR_W, default 12, APB address width driven to slaves.
REQ-004 SHALL have parameter BASE_HI, default 16'h1000, required value of addr[31:16] for a mapped access.
REQ-005 SHALL have parameter TIMEOUT_CYC, default 255, maximum ACCESS-phase cycles waiting for PREADY (1..65535).
REQ-006 SHALL have one clock and one reset: PCLK in 1 (APB clock, rising edge); PRESET in 1 (asynchronous, active-low reset).
REQ-007 SHALL have CPU-side ports: transfer in 1 (request pulse); write in 1 (1=write); addr in 32 (byte address); wdata in DATA_W; strb in DATA_W/8 (write byte enables); ready out 1 (completion pulse); rdata out DATA_W (read data); error out 1 (completion with error).
REQ-008 SHALL have APB-side ports: PADDR out PADDR_W; PWRITE out 1; PENABLE out 1; PWDATA out DATA_W; PSTRB out DATA_W/8; PSEL out NUM_SLAVES (one-hot); PRDATA in NUM_SLAVES*DATA_W (slave i at bits [i*DATA_W +: DATA_W]); PREADY in NUM_SLAVES; PSLVERR in NUM_SLAVES.

Function
REQ-009 SHALL decode slave index = addr[15:12]; access mapped iff addr[31:16]==BASE_HI and index<NUM_SLAVES.
REQ-010 SHALL implement FSM states IDLE, SETUP, ACCESS, RESP.
REQ-011 IDLE: on transfer=1 SHALL latch write, addr, wdata, strb and decoded index; go to SETUP if mapped, else RESP with error pending.
REQ-012 SETUP (exactly one cycle): PSEL[index]=1, PENABLE=0, PADDR=addr[PADDR_W-1:0], PWRITE/PWDATA/PSTRB from latch; then ACCESS.
REQ-013 ACCESS: PSEL[index]=1, PENABLE=1; PADDR/PWRITE/PWDATA/PSTRB SHALL stay stable until exit.
REQ-014 ACCESS with PREADY[index]=1: SHALL capture PRDATA slice index (reads) and PSLVERR[index] in registers, go to RESP.
REQ-015 ACCESS with PREADY[index]=0: SHALL increment wait counter; on reaching TIMEOUT_CYC SHALL go to RESP with error pending, rdata forced 0; wait counter cleared on SETUP entry.
REQ-016 RESP (exactly one cycle): ready=1, error=captured/pending error, rdata valid (0 for writes, errored or unmapped accesses); PSEL all 0, PENABLE=0; then IDLE.
REQ-017 Minimum latency: transfer cycle N, SETUP N+1, ACCESS N+2 with PREADY=1, ready at N+3; unmapped: ready+error at N+1.
REQ-018 transfer asserted outside IDLE SHALL be ignored; transfer in RESP cycle SHALL NOT be accepted (accepted earliest the following IDLE cycle).
REQ-019 PREADY/PSLVERR/PRDATA of unselected slaves SHALL be ignored at all times.
REQ-020 PSLVERR sampled only with PREADY=1 in ACCESS; error on a write SHALL NOT alter anything beyond error=1 in RESP.
REQ-021 PSEL SHALL never have more than one bit set; PENABLE=1 only in ACCESS.
REQ-022 ready and error SHALL be registered outputs, high for one cycle only.

Reset
REQ-023 PRESET low SHALL asynchronously force state IDLE, PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, PSTRB=0, ready=0, error=0, rdata=0, wait counter=0.
REQ-024 Reset asserted mid-transfer SHALL abort it with no ready pulse; first transfer accepted on the first rising edge after PRESET deasserts.

Structure
REQ-025 Shared package apb_pkg SHALL hold the state enum (IDLE, SETUP, ACCESS, RESP) and BASE_HI/decode-field constants.
REQ-026 Address decode SHALL be a separate sub-module apb_decoder (addr in; index, mapped out), combinational; FSM and datapath in apb_master_n.

Verification
REQ-027 Read slave 2, addr 0x1000_2004, PREADY=1 immediately, PRDATA2=0xDEAD_BEEF -> PSEL=0b00000100 cycles N+1..N+2, PADDR=0x004, ready+rdata=0xDEAD_BEEF at N+3, error=0.
REQ-028 Write slave 0, addr 0x1000_0010, wdata 0x1234_5678, strb 0xF, PREADY held low 3 ACCESS cycles -> PENABLE 4 cycles, PWDATA stable, ready at N+6, rdata=0.
REQ-029 Unmapped addr 0x2000_0000 and index 9 with NUM_SLAVES=8 -> no PSEL, ready=1 error=1 at N+1.
REQ-030 TIMEOUT_CYC=4, PREADY stuck low -> ACCESS 4 cycles, then ready=1 error=1 rdata=0, PSEL cleared.
REQ-031 PSLVERR3=1 with PREADY3=1 on read of 0x1000_3000 -> ready=1 error=1 rdata=PRDATA3 sample; PSLVERR5=1 concurrently has no effect.
REQ-032 PRESET low during ACCESS -> all outputs 0 immediately, no ready; transfer after release -> normal N+3 completion.
